// File: rtl/phase_timer.sv
// phase_timer: per-phase green/yellow/all-red lamp timer that hands off to the side-selection FSM
module phase_timer #(
  parameter int GREEN_HIGH = 20,
  parameter int GREEN_LOW  = 10,
  parameter int YELLOW_T   = 3,
  parameter int ALLRED_T   = 1,
  parameter int CNT_W      = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             En,
  input  logic [1:0]       Side,
  input  logic             T1,
  input  logic             T2,
  input  logic             T3,
  input  logic             T4,
  output logic             Next,
  output logic [3:0]       Green,
  output logic [3:0]       Yellow,
  output logic [3:0]       Red,
  output logic [CNT_W-1:0] Remaining
);
  typedef enum logic [2:0] {LOAD, GREEN, YELLOW, ALLRED, HANDOFF} state_t;
  localparam logic [CNT_W-1:0] GH_C = CNT_W'((GREEN_HIGH == 0) ? 1 : GREEN_HIGH);
  localparam logic [CNT_W-1:0] GL_C = CNT_W'((GREEN_LOW == 0) ? 1 : GREEN_LOW);
  localparam logic [CNT_W-1:0] Y_C  = CNT_W'((YELLOW_T == 0) ? 1 : YELLOW_T);
  localparam logic [CNT_W-1:0] AR_C = CNT_W'(ALLRED_T);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0] t_all, side_oh;
  logic dens, last;
  assign t_all   = {T4, T3, T2, T1};
  assign dens    = t_all[Side];
  assign side_oh = 4'b0001 << Side;
  assign last    = En && (cnt_q <= CNT_W'(1));
  // state and phase counter, cleared immediately on reset
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= LOAD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // phase sequencing: the final En tick of a phase loads the next phase's duration
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      LOAD: begin
        state_d = GREEN;
        cnt_d   = dens ? GH_C : GL_C;
      end
      GREEN: begin
        if (last) begin
          state_d = YELLOW;
          cnt_d   = Y_C;
        end else if (En) cnt_d = cnt_q - CNT_W'(1);
      end
      YELLOW: begin
        if (last) begin
          if (ALLRED_T == 0) state_d = HANDOFF;
          else state_d = ALLRED;
          cnt_d = AR_C;
        end else if (En) cnt_d = cnt_q - CNT_W'(1);
      end
      ALLRED: begin
        if (last) begin
          state_d = HANDOFF;
          cnt_d   = '0;
        end else if (En) cnt_d = cnt_q - CNT_W'(1);
      end
      HANDOFF: begin
        state_d = LOAD;
        cnt_d   = '0;
      end
      default: begin
        state_d = LOAD;
        cnt_d   = '0;
      end
    endcase
  end
  // lamps and handoff decoded from registered state; lamps track Side directly
  always_comb begin
    Green     = (state_q == GREEN) ? side_oh : 4'h0;
    Yellow    = (state_q == YELLOW) ? side_oh : 4'h0;
    Red       = ~(Green | Yellow);
    Next      = (state_q == HANDOFF);
    Remaining = (state_q inside {GREEN, YELLOW, ALLRED}) ? cnt_q : '0;
  end
endmodule

// File: tb/tb_phase_timer.sv
// tb_phase_timer: directed checks of phase_timer timing, lamps and handoff
module tb_phase_timer;
  logic Clk = 1'b0;
  logic Reset_n, rst2_n, En, T1, T2, T3, T4;
  logic [1:0] Side;
  logic n1, n2;
  logic [3:0] g1, y1, r1, g2, y2, r2;
  logic [7:0] rem1, rem2;
  int checks, failures;

  phase_timer u1 (
    .Clk(Clk), .Reset_n(Reset_n), .En(En), .Side(Side),
    .T1(T1), .T2(T2), .T3(T3), .T4(T4),
    .Next(n1), .Green(g1), .Yellow(y1), .Red(r1), .Remaining(rem1)
  );

  phase_timer #(.GREEN_LOW(0), .ALLRED_T(0)) u2 (
    .Clk(Clk), .Reset_n(rst2_n), .En(En), .Side(Side),
    .T1(T1), .T2(T2), .T3(T3), .T4(T4),
    .Next(n2), .Green(g2), .Yellow(y2), .Red(r2), .Remaining(rem2)
  );

  always #5 Clk = ~Clk;

  task automatic run_phase(input bit sel, input logic [1:0] sd, input int g, input int y,
                           input int a, input bit tog);
    logic [20:0] obs, exp_v;
    logic [3:0] oh, eg, ey;
    logic [7:0] er;
    oh = 4'b0001 << sd;
    for (int k = 0; k <= g + y + a + 1; k++) begin
      if (k > 0) @(negedge Clk);
      if (tog && k == 3) {T4, T3, T2, T1} = ~{T4, T3, T2, T1};
      eg = (k >= 1 && k <= g) ? oh : 4'h0;
      ey = (k > g && k <= g + y) ? oh : 4'h0;
      er = (k >= 1 && k <= g) ? 8'(g + 1 - k) :
           (k > g && k <= g + y) ? 8'(g + y + 1 - k) :
           (k > g + y && k <= g + y + a) ? 8'(g + y + a + 1 - k) : 8'd0;
      exp_v = {eg, ey, ~(eg | ey), k == g + y + a + 1, er};
      obs = sel ? {g2, y2, r2, n2, rem2} : {g1, y1, r1, n1, rem1};
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL phase sel=%0d side=%0d k=%0d got=%h exp=%h", sel, sd, k, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge Clk);
    checks++;
    if ({g1, y1, r1, n1, rem1} !== {4'h0, 4'h0, 4'hF, 1'b0, 8'h0}) begin
      failures++;
      $display("FAIL reset_u1 got=%h exp=%h", {g1, y1, r1, n1, rem1}, {4'h0, 4'h0, 4'hF, 1'b0, 8'h0});
    end
    checks++;
    if ({g2, y2, r2, n2, rem2} !== {4'h0, 4'h0, 4'hF, 1'b0, 8'h0}) begin
      failures++;
      $display("FAIL reset_u2 got=%h exp=%h", {g2, y2, r2, n2, rem2}, {4'h0, 4'h0, 4'hF, 1'b0, 8'h0});
    end
    Reset_n = 1'b1;
  endtask

  task automatic test_green_high;
    run_phase(1'b0, 2'd0, 20, 3, 1, 1'b0);
  endtask

  task automatic test_density_latch;
    {T4, T3, T2, T1} = 4'b0000;
    Side = 2'd0;
    @(negedge Clk);
    run_phase(1'b0, 2'd0, 10, 3, 1, 1'b1);
  endtask

  task automatic test_side_sequence;
    Side = 2'd1;
    {T4, T3, T2, T1} = 4'b0010;
    @(negedge Clk);
    run_phase(1'b0, 2'd1, 20, 3, 1, 1'b0);
    Side = 2'd2;
    {T4, T3, T2, T1} = 4'b0000;
    @(negedge Clk);
    run_phase(1'b0, 2'd2, 10, 3, 1, 1'b0);
    Side = 2'd3;
    {T4, T3, T2, T1} = 4'b1000;
    @(negedge Clk);
    run_phase(1'b0, 2'd3, 20, 3, 1, 1'b0);
  endtask

  task automatic test_slow_en;
    int gt, yt, at;
    bit done;
    gt = 0; yt = 0; at = 0; done = 1'b0;
    Side = 2'd0;
    {T4, T3, T2, T1} = 4'b0001;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge Clk);
      En = (c == 0) || (c % 4 == 0);
      if (n1) done = 1'b1;
      else if (En) begin
        if (g1 == 4'h1) gt++;
        else if (y1 == 4'h1) yt++;
        else if (rem1 != 8'd0) at++;
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL slow_en_timeout got=no_next exp=next_within_400");
    end
    checks++;
    if (gt !== 20) begin
      failures++;
      $display("FAIL slow_en_green_ticks got=%0d exp=20", gt);
    end
    checks++;
    if (yt !== 3) begin
      failures++;
      $display("FAIL slow_en_yellow_ticks got=%0d exp=3", yt);
    end
    checks++;
    if (at !== 1) begin
      failures++;
      $display("FAIL slow_en_allred_ticks got=%0d exp=1", at);
    end
    En = 1'b1;
  endtask

  task automatic test_async_reset;
    Side = 2'd0;
    {T4, T3, T2, T1} = 4'b0001;
    repeat (6) @(negedge Clk);
    checks++;
    if ({g1, rem1} !== {4'h1, 8'd16}) begin
      failures++;
      $display("FAIL mid_green got=%h exp=%h", {g1, rem1}, {4'h1, 8'd16});
    end
    #2 Reset_n = 1'b0;
    #1;
    checks++;
    if ({g1, y1, r1, n1, rem1} !== {4'h0, 4'h0, 4'hF, 1'b0, 8'h0}) begin
      failures++;
      $display("FAIL async_reset got=%h exp=%h", {g1, y1, r1, n1, rem1}, {4'h0, 4'h0, 4'hF, 1'b0, 8'h0});
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    run_phase(1'b0, 2'd0, 20, 3, 1, 1'b0);
  endtask

  task automatic test_allred_zero;
    int pulses;
    bit prev;
    Side = 2'd0;
    {T4, T3, T2, T1} = 4'b0000;
    rst2_n = 1'b1;
    run_phase(1'b1, 2'd0, 1, 3, 0, 1'b0);
    pulses = 0;
    prev = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge Clk);
      if (n2) pulses++;
      checks++;
      if ((|g2 && |y2) || (n2 && prev)) begin
        failures++;
        $display("FAIL allred0_cycle c=%0d got=g%h_y%h_n%b exp=no_overlap", c, g2, y2, n2);
      end
      prev = n2;
    end
    checks++;
    if (pulses !== 2) begin
      failures++;
      $display("FAIL allred0_next_count got=%0d exp=2", pulses);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    Reset_n = 1'b0;
    rst2_n = 1'b0;
    En = 1'b1;
    Side = 2'd0;
    {T4, T3, T2, T1} = 4'b0001;
    test_reset;
    test_green_high;
    test_density_latch;
    test_side_sequence;
    test_slow_en;
    test_async_reset;
    test_allred_zero;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
